// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: 32-step shift-add multiply and
// restoring divide on operand magnitudes, with the sign fixup applied at commit.
module md_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(ITER);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          is_div;
  logic          neg_q;
  logic          neg_r;
  logic [31:0]   opnd;
  logic [31:0]   wh;
  logic [31:0]   wl;
  logic          sgnd;

  logic [32:0]   msum;
  logic [32:0]   dshift;
  logic [33:0]   dtrial;
  logic [63:0]   prod;
  logic [31:0]   quo;
  logic [31:0]   rem;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    logic signed [31:0] sx;
    sx = x;
    return (is_signed && sx < 0) ? 32'(-sx) : x;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
    return en ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
    return en ? (~x + 64'd1) : x;
  endfunction

  assign sgnd = ~op[0];
  assign busy = (state != IDLE);

  // Per-iteration datapath: wh is the accumulator/remainder, wl the multiplier/quotient.
  always_comb begin
    msum   = {1'b0, wh} + (wl[0] ? {1'b0, opnd} : 33'd0);
    dshift = {wh, wl[31]};
    dtrial = {1'b0, dshift} - {2'b00, opnd};
    prod   = neg64({wh, wl}, neg_q);
    rem    = neg32(wh, neg_r);
    quo    = (opnd == 32'd0) ? 32'hFFFF_FFFF : neg32(wl, neg_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      wh     <= '0;
      wl     <= '0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start && !flush) begin
            state  <= CALC;
            count  <= '0;
            is_div <= op[1];
            neg_q  <= sgnd & (A[31] ^ B[31]);
            neg_r  <= sgnd & A[31];
            wh     <= '0;
            // Multiply keeps the multiplicand in opnd; divide keeps the divisor there.
            opnd   <= op[1] ? mag32(B, sgnd) : mag32(A, sgnd);
            wl     <= op[1] ? mag32(A, sgnd) : mag32(B, sgnd);
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              if (!dtrial[33]) begin
                wh <= dtrial[31:0];
                wl <= {wl[30:0], 1'b1};
              end else begin
                wh <= dshift[31:0];
                wl <= {wl[30:0], 1'b0};
              end
            end else begin
              wh <= msum[32:1];
              wl <= {msum[0], wl[31:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(ITER - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            HI   <= is_div ? rem : prod[63:32];
            LO   <= is_div ? quo : prod[31:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus randomized back-to-back operations
// compared against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int  tests = 0;
  int  fails = 0;
  time last_done_t = 0;

  md_unit #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain 64-bit arithmetic and SV division semantics.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, sq, sr;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin sp = 64'(sa) * 64'(sb); return sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    tick();
    start = 1'b0;
  endtask

  // Called in the cycle after the start edge; pre = busy cycles already elapsed.
  task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el, input int pre);
    int bc;
    bc = pre;
    check({tag, ".no_done_at_launch"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (busy) bc++;
      tick();
    end
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".busy_cycles"}, bc, 32'd33);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".HI"}, HI, eh);
    check({tag, ".LO"}, LO, el);
    last_done_t = $time;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = ref_md(o, a, b);
    launch(o, a, b);
    wait_done(tag, e[63:32], e[31:0], 0);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] sh, sl, ra, rb;
    logic [1:0]  ro;
    time t0;
    int  seen;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick();
    tick();
    check("reset.HI", HI, 32'd0);
    check("reset.LO", LO, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    check("multu_max.single_pulse", {31'd0, done}, 32'd0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0);
    tick();

    // MTHI, then MULTU with a second start and an MTLO attempted while busy.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0;
    check("mthi.HI", HI, 32'h1234_5678);
    launch(2'b01, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    lo_we = 1'b0;
    wait_done("ignore_start", 32'd0, 32'd12, 6);
    tick();
    check("ignore_start.idle_after", {31'd0, busy}, 32'd0);

    // Flush at busy cycle 10 discards the divide; an immediate restart commits.
    sh = HI; sl = LO;
    launch(2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", {31'd0, busy}, 32'd0);
    check("flush.done", {31'd0, done}, 32'd0);
    check("flush.HI", HI, sh);
    check("flush.LO", LO, sl);
    run_op("after_flush", 2'b11, 32'd100, 32'd7);
    tick();
    flush = 1'b1; start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle.busy", {31'd0, busy}, 32'd0);
    check("flush_start_idle.LO", LO, 32'd14);

    // Reset during a MULT: no commit, no done.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    launch(2'b00, 32'hFFFF_FFF3, 32'd77);
    for (int i = 0; i < 19; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset.HI", HI, 32'd0);
    check("midreset.LO", LO, 32'd0);
    check("midreset.busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen++;
      tick();
    end
    check("midreset.no_done", seen, 32'd0);

    // Randomized back-to-back chain: each start is issued in the previous done cycle.
    run_op("b2b_first", 2'b01, 32'd6, 32'd7);
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      e = ref_md(ro, ra, rb);
      t0 = last_done_t;
      launch(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d_%h_%h", n, ro, ra, rb), e[63:32], e[31:0], 0);
      check($sformatf("rand%0d.spacing", n), 32'(last_done_t - t0), 32'd340);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
